pdm_mic_ctrl: RTL and testbench

Sequencer and output buffer for the PDM microphone decimation chain.
- Owns the decimator's reset: holds it off during microphone wake-up.
- Discards the CIC settling transient.
- Buffers decimated samples in a small FWFT FIFO with valid/ready handshake toward the MCU/SPI side.
- Runs in the PDM clock domain, so clk is the same clock that feeds the decimator.

---
 rtl/pdm_mic_pkg.sv | 17 +
 rtl/pdm_sample_fifo.sv | 59 +++++
 rtl/pdm_mic_ctrl.sv | 128 ++++++++++++
 tb/tb_pdm_mic_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_mic_pkg.sv
// Shared types and default constants for the PDM microphone capture path.
package pdm_mic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKE   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DEF_DATA_W         = 16;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_WAKE_CYCLES    = 30000;
    localparam int DEF_SETTLE_SAMPLES = 4;
    localparam int DROP_CNT_W         = 16;

endpackage

// File: rtl/pdm_sample_fifo.sv
// First-word-fall-through sample FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module pdm_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_pop;
    logic              do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM mic sequencer: wake hold-off, CIC settle discard, sample buffer.
// Define PDM_MIC_CTRL_DROP_CNT_EN to build the dropped-sample counter.
module pdm_mic_ctrl
    import pdm_mic_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int WAKE_CYCLES    = DEF_WAKE_CYCLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  cic_rst_n,
    input  logic [DATA_W-1:0]     cic_dout,
    input  logic                  cic_valid,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LW-1:0]         fifo_level,
    output logic [1:0]            state,
    output logic                  overflow,
    input  logic                  clear_ovf,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int WCW = $clog2(WAKE_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_SAMPLES + 2);

    state_t         st;
    logic [WCW-1:0] wake_cnt;
    logic [SCW-1:0] settle_cnt;
    logic           wake_entry;
    logic           push;
    logic           full;
    logic           empty;
    logic           drop;

    assign wake_entry = (st == IDLE) && enable;
    assign push       = (st == RUN) && cic_valid;
    assign drop       = push && full && !m_ready;
    assign m_valid    = !empty;
    assign state      = st;

    pdm_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (wake_entry),
        .push    (push),
        .pop     (m_ready),
        .din     (cic_dout),
        .dout    (m_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= IDLE;
            cic_rst_n  <= 1'b0;
            wake_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    cic_rst_n <= 1'b0;
                    wake_cnt  <= '0;
                    if (enable) st <= WAKE;
                end
                WAKE: begin
                    if (!enable) begin
                        st <= IDLE;
                    end else if (wake_cnt == WCW'(WAKE_CYCLES - 1)) begin
                        st         <= (SETTLE_SAMPLES == 0) ? RUN : SETTLE;
                        cic_rst_n  <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!enable) begin
                        st        <= IDLE;
                        cic_rst_n <= 1'b0;
                    end else if (cic_valid) begin
                        if (settle_cnt == SCW'(SETTLE_SAMPLES - 1)) st <= RUN;
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        st        <= IDLE;
                        cic_rst_n <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        overflow <= 1'b0;
        else if (wake_entry) overflow <= 1'b0;
        else if (drop)       overflow <= 1'b1;
        else if (clear_ovf)  overflow <= 1'b0;
    end

`ifdef PDM_MIC_CTRL_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                drop_q <= '0;
        else if (wake_entry)         drop_q <= '0;
        else if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed bench for pdm_mic_ctrl with a queue model of the sample FIFO.
module tb_pdm_mic_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int WAKE  = 8;
    localparam int SETL  = 4;
`ifdef PDM_MIC_CTRL_DROP_CNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          cic_rst_n;
    logic [DW-1:0] cic_dout;
    logic          cic_valid;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2:0]    fifo_level;
    logic [1:0]    state;
    logic          overflow;
    logic          clear_ovf;
    logic [15:0]   drop_cnt;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    int exp_drop = 0;

    pdm_mic_ctrl #(
        .DATA_W         (DW),
        .FIFO_DEPTH     (DEPTH),
        .WAKE_CYCLES    (WAKE),
        .SETTLE_SAMPLES (SETL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .cic_rst_n  (cic_rst_n),
        .cic_dout   (cic_dout),
        .cic_valid  (cic_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .state      (state),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe one decimated sample; mdl says the DUT is in RUN.
    task automatic strobe(input logic [DW-1:0] d, input bit mdl);
        if (mdl) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_drop++;
        end
        cic_dout  = d;
        cic_valid = 1'b1;
        step();
        cic_valid = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        logic [DW-1:0] e;
        chk({tag, "_valid"}, 32'(m_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_data"}, 32'(m_data), 32'(e));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic chk_drop(input string tag);
        chk(tag, 32'(drop_cnt), DC_EN ? 32'(exp_drop) : 32'd0);
    endtask

    task automatic wake_to_run();
        for (int i = 0; i < WAKE - 1; i++) begin
            step();
            chk("wake_hold", {30'd0, state}, 32'd1);
            chk("wake_rst", 32'(cic_rst_n), 32'd0);
        end
        step();
        chk("settle_state", {30'd0, state}, 32'd2);
        chk("settle_rst", 32'(cic_rst_n), 32'd1);
        for (int i = 1; i <= SETL; i++) strobe(DW'(i), 1'b0);
        chk("run_state", {30'd0, state}, 32'd3);
        chk("run_level", 32'(fifo_level), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        cic_dout  = '0;
        cic_valid = 1'b0;
        m_ready   = 1'b0;
        clear_ovf = 1'b0;
        step();
        step();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cic", 32'(cic_rst_n), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_mdata", 32'(m_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_state", {30'd0, state}, 32'd0);

        // wake sequence and settle discard
        enable = 1'b1;
        step();
        chk("wake_state", {30'd0, state}, 32'd1);
        chk("wake_rst0", 32'(cic_rst_n), 32'd0);
        wake_to_run();
        strobe(16'd5, 1'b1);
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_data", 32'(m_data), 32'd5);
        strobe(16'd6, 1'b1);
        pop_one("pop5");
        pop_one("pop6");
        chk("drained", 32'(m_valid), 32'd0);

        // overflow with consumer stalled
        for (int i = 0; i < 6; i++) strobe(DW'(10 + i), 1'b1);
        chk("full_level", 32'(fifo_level), 32'(exp_q.size()));
        chk("full_head", 32'(m_data), 32'(exp_q[0]));
        chk("ovf_set", 32'(overflow), 32'd1);
        chk_drop("drop2");

        // full FIFO: push with simultaneous pop is accepted
        chk("fp_head", 32'(m_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        exp_q.push_back(16'd20);
        cic_dout  = 16'd20;
        cic_valid = 1'b1;
        m_ready   = 1'b1;
        step();
        cic_valid = 1'b0;
        m_ready   = 1'b0;
        chk("fp_level", 32'(fifo_level), 32'd4);
        chk("fp_ovf", 32'(overflow), 32'd1);
        chk("fp_next", 32'(m_data), 32'(exp_q[0]));
        chk_drop("fp_drop");

        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        clear_ovf = 1'b1;
        strobe(16'd21, 1'b1);
        clear_ovf = 1'b0;
        chk("set_wins", 32'(overflow), 32'd1);
        chk_drop("drop3");

        // disable in RUN; same-cycle strobe still lands
        pop_one("pre_dis");
        enable = 1'b0;
        strobe(16'd30, 1'b1);
        chk("dis_state", {30'd0, state}, 32'd0);
        chk("dis_rst", 32'(cic_rst_n), 32'd0);
        chk("dis_level", 32'(fifo_level), 32'(exp_q.size()));
        strobe(16'd40, 1'b0);
        chk("idle_nopush", 32'(fifo_level), 32'(exp_q.size()));
        pop_one("idle_d0");
        pop_one("idle_d1");
        pop_one("idle_d2");

        // re-enable flushes the remaining entry and clears flags
        enable = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        step();
        chk("re_state", {30'd0, state}, 32'd1);
        chk("re_level", 32'(fifo_level), 32'd0);
        chk("re_mvalid", 32'(m_valid), 32'd0);
        chk("re_ovf", 32'(overflow), 32'd0);
        chk_drop("re_drop");

        // async reset in RUN with data and overflow pending
        wake_to_run();
        for (int i = 0; i < 5; i++) strobe(DW'(50 + i), 1'b1);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_state", {30'd0, state}, 32'd0);
        chk("ar_cic", 32'(cic_rst_n), 32'd0);
        chk("ar_mvalid", 32'(m_valid), 32'd0);
        chk("ar_mdata", 32'(m_data), 32'd0);
        chk("ar_level", 32'(fifo_level), 32'd0);
        chk("ar_ovf", 32'(overflow), 32'd0);
        chk("ar_drop", 32'(drop_cnt), 32'd0);
        step();
        enable  = 1'b0;
        reset_n = 1'b1;
        step();
        chk("post_rst_state", {30'd0, state}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
